// File: rtl/external_interrupt_controller.sv
// IO-mapped interrupt controller: reloadable interval timer plus one synchronised
// external line, feeding a prioritised level request (timer first) to the core.
module external_interrupt_controller #(
    parameter logic [29:0] BASE_ADDR = 30'h0000_0100
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        IO_EnR,
    input  logic        IO_EnW,
    input  logic [29:0] IO_Address,
    input  logic [31:0] IO_DataW,
    output logic [31:0] IO_DataR,
    input  logic        Ext_Irq,
    output logic        EIC_I_Req,
    output logic        EIC_I_Id
);

    logic [4:0]  r_ctrl;
    logic [1:0]  r_pend;
    logic [31:0] r_load;
    logic [31:0] r_count;
    logic        r_s1;
    logic        r_s2;
    logic        r_h;
    logic [31:0] r_dataR;

    logic [29:0] w_offset;
    logic        w_hit;
    logic [2:0]  w_sel;
    logic        w_wrCtrl;
    logic        w_wrPend;
    logic        w_wrLoad;
    logic        w_wrCount;
    logic        w_p0Set;
    logic        w_p1Set;
    logic [1:0]  w_pendClr;
    logic        w_src0;
    logic        w_src1;
    logic [31:0] w_readData;

    // Addresses below BASE_ADDR wrap to a large offset, so one compare covers both ends.
    assign w_offset  = IO_Address - BASE_ADDR;
    assign w_hit     = (w_offset < 30'd5);
    assign w_sel     = w_offset[2:0];

    assign w_wrCtrl  = IO_EnW & w_hit & (w_sel == 3'd0);
    assign w_wrPend  = IO_EnW & w_hit & (w_sel == 3'd1);
    assign w_wrLoad  = IO_EnW & w_hit & (w_sel == 3'd2);
    assign w_wrCount = IO_EnW & w_hit & (w_sel == 3'd3);

    assign w_p0Set   = r_ctrl[3] & (r_count == 32'd0) & ~w_wrCount;
    assign w_p1Set   = r_ctrl[4] ? (~r_s2 & r_h) : (r_s2 & ~r_h);
    assign w_pendClr = w_wrPend ? IO_DataW[1:0] : 2'b00;

    assign w_src0    = r_pend[0] & r_ctrl[1];
    assign w_src1    = r_pend[1] & r_ctrl[2];
    assign EIC_I_Req = r_ctrl[0] & (w_src0 | w_src1);
    assign EIC_I_Id  = EIC_I_Req & ~w_src0;

    assign IO_DataR  = r_dataR;

    always_comb begin
        w_readData = '0;
        if (w_hit) begin
            case (w_sel)
                3'd0:    w_readData = {27'd0, r_ctrl};
                3'd1:    w_readData = {30'd0, r_pend};
                3'd2:    w_readData = r_load;
                3'd3:    w_readData = r_count;
                3'd4:    w_readData = {30'd0, EIC_I_Req, EIC_I_Id};
                default: w_readData = '0;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_ctrl  <= '0;
            r_pend  <= '0;
            r_load  <= '0;
            r_count <= '0;
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_h     <= 1'b0;
            r_dataR <= '0;
        end else begin
            r_s1 <= Ext_Irq;
            r_s2 <= r_s1;
            r_h  <= r_s2;

            if (w_wrCtrl)
                r_ctrl <= IO_DataW[4:0];
            if (w_wrLoad)
                r_load <= IO_DataW;

            // A software COUNT write overrides both decrement and reload.
            if (w_wrCount)
                r_count <= IO_DataW;
            else if (r_ctrl[3])
                r_count <= (r_count == 32'd0) ? r_load : (r_count - 32'd1);

            r_pend <= (r_pend & ~w_pendClr) | {w_p1Set, w_p0Set};

            if (IO_EnR)
                r_dataR <= w_readData;
        end
    end

endmodule
